// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control unit: state encoding,
// opcode/ALU constants, IR field positions and the opcode decoder.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_RST  = 3'd0,
        ST_T0   = 3'd1,
        ST_T1   = 3'd2,
        ST_T2   = 3'd3,
        ST_T3   = 3'd4,
        ST_T4   = 3'd5,
        ST_T5   = 3'd6,
        ST_HALT = 3'd7
    } state_e;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b01000;
    localparam logic [4:0] OP_OR   = 5'b01001;

    localparam logic [4:0] ALU_NOP = 5'b00000;
    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_SUB = 5'b00100;
    localparam logic [4:0] ALU_AND = 5'b01001;
    localparam logic [4:0] ALU_OR  = 5'b01010;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 27;
    localparam int RA_MSB     = 26;
    localparam int RA_LSB     = 23;
    localparam int RB_MSB     = 22;
    localparam int RB_LSB     = 19;
    localparam int RC_MSB     = 18;
    localparam int RC_LSB     = 15;

    typedef struct packed {
        logic       legal;
        logic [4:0] aluop;
    } op_decode_t;

    // Opcode and ALU codes differ for AND/OR, so the mapping is explicit.
    function automatic op_decode_t decode_opcode(input logic [4:0] opcode);
        op_decode_t d;
        d.legal = 1'b1;
        d.aluop = ALU_NOP;
        case (opcode)
            OP_ADD:  d.aluop = ALU_ADD;
            OP_SUB:  d.aluop = ALU_SUB;
            OP_AND:  d.aluop = ALU_AND;
            OP_OR:   d.aluop = ALU_OR;
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/reg_select.sv
// Select-and-encode stage: picks Ra/Rb/Rc from IR and produces one-hot
// register-file write and bus-drive enables.
module reg_select
    import cpu_pkg::*;
(
    input  logic [31:0] IR,
    input  logic        Gra,
    input  logic        Grb,
    input  logic        Grc,
    input  logic        Rin_en,
    input  logic        Rout_en,
    output logic [15:0] Rin,
    output logic [15:0] Rout
);

    logic [3:0]  regSel;
    logic [15:0] oneHot;
    logic        unused_ir;

    assign unused_ir = ^{IR[OPCODE_MSB:OPCODE_LSB], IR[RC_LSB-1:0]};

    // Priority among the selects only matters if the sequencer misbehaves.
    always_comb begin
        regSel = 4'd0;
        if (Gra) begin
            regSel = IR[RA_MSB:RA_LSB];
        end else if (Grb) begin
            regSel = IR[RB_MSB:RB_LSB];
        end else if (Grc) begin
            regSel = IR[RC_MSB:RC_LSB];
        end
        oneHot = 16'h0001 << regSel;
        Rin    = Rin_en  ? oneHot : 16'h0000;
        Rout   = Rout_en ? oneHot : 16'h0000;
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T0-T5 control unit for three-register ALU instructions, with
// retired-instruction counter and halt-on-request at instruction boundaries.
module control_sequencer
    import cpu_pkg::*;
(
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        IncPC,
    output logic        Read,
    output logic [4:0]  ALUop,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic        Run,
    output logic        Illegal,
    output logic [15:0] InstrCount
);

    state_e      state_q;
    state_e      state_d;
    logic [15:0] count_q;
    op_decode_t  opDec;
    logic        gra;
    logic        grb;
    logic        grc;
    logic        rinEn;
    logic        routEn;

    assign opDec = decode_opcode(IR[OPCODE_MSB:OPCODE_LSB]);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RST:  state_d = ST_T0;
            ST_T0:   state_d = ST_T1;
            ST_T1:   state_d = ST_T2;
            ST_T2:   state_d = ST_T3;
            ST_T3:   begin
                if (opDec.legal) begin
                    state_d = ST_T4;
                end else begin
                    state_d = Stop ? ST_HALT : ST_T0;
                end
            end
            ST_T4:   state_d = ST_T5;
            ST_T5:   state_d = Stop ? ST_HALT : ST_T0;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RST;
        endcase
    end

    // Every T5 exit retires an instruction, whether it heads to T0 or HALT.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q <= ST_RST;
            count_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            if (state_q == ST_T5) begin
                count_q <= count_q + 16'h0001;
            end
        end
    end

    always_comb begin
        PCout   = 1'b0;
        Zlowout = 1'b0;
        MDRout  = 1'b0;
        MARin   = 1'b0;
        PCin    = 1'b0;
        MDRin   = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        Zin     = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        ALUop   = ALU_NOP;
        Illegal = 1'b0;
        gra     = 1'b0;
        grb     = 1'b0;
        grc     = 1'b0;
        rinEn   = 1'b0;
        routEn  = 1'b0;
        Run     = 1'b0;
        case (state_q)
            ST_T0: begin
                Run   = 1'b1;
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            ST_T1: begin
                Run     = 1'b1;
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            ST_T2: begin
                Run    = 1'b1;
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            ST_T3: begin
                Run     = 1'b1;
                grb     = 1'b1;
                routEn  = 1'b1;
                Yin     = 1'b1;
                Illegal = !opDec.legal;
            end
            ST_T4: begin
                Run    = 1'b1;
                grc    = 1'b1;
                routEn = 1'b1;
                Zin    = 1'b1;
                ALUop  = opDec.aluop;
            end
            ST_T5: begin
                Run     = 1'b1;
                Zlowout = 1'b1;
                gra     = 1'b1;
                rinEn   = 1'b1;
            end
            default: ;
        endcase
    end

    reg_select u_reg_select (
        .IR      (IR),
        .Gra     (gra),
        .Grb     (grb),
        .Grc     (grc),
        .Rin_en  (rinEn),
        .Rout_en (routEn),
        .Rin     (Rin),
        .Rout    (Rout)
    );

    assign InstrCount = count_q;

endmodule
